// File: rtl/trace_pkg.sv
// trace_pkg: shared entry layout and sizing helper for the commit trace buffer
package trace_pkg;
  localparam int TRACE_FLAG_W = 3;
  localparam int TRACE_SEQ_W = 32;
  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] dnpc;
    logic device;
    logic invalid;
    logic kill;
    logic [TRACE_SEQ_W-1:0] seq;
  } trace_entry_t;
  function automatic int clog2_safe(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/commit_compact.sv
// commit_compact: packs set mask bits into ascending source-channel slots and counts them
module commit_compact
  import trace_pkg::*;
#(
  parameter int NCH = 2,
  localparam int IW = clog2_safe(NCH),
  localparam int NW = clog2_safe(NCH + 1)
) (
  input  logic [NCH-1:0]    mask,
  output logic [NCH*IW-1:0] src,
  output logic [NW-1:0]     npush
);
  always_comb begin
    int k;
    src = '0;
    k = 0;
    for (int i = 0; i < NCH; i++) begin
      if (mask[i]) begin
        src[k*IW +: IW] = IW'(i);
        k++;
      end
    end
    npush = NW'(k);
  end
endmodule

// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer: multi-lane retire capture into a FIFO drained one entry per cycle to the trace sink
module commit_trace_buffer
  import trace_pkg::*;
#(
  parameter int NCH = 2,
  parameter int DEPTH = 16,
  parameter int SEQ_W = 32,
  parameter int TIMEOUT = 4096,
  parameter int DROP_KILLED = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NCH-1:0]          commit_valid,
  input  logic [32*NCH-1:0]       commit_inst,
  input  logic [64*NCH-1:0]       commit_dnpc,
  input  logic [NCH-1:0]          commit_kill,
  input  logic [NCH-1:0]          commit_invalid,
  input  logic [NCH-1:0]          commit_device,
  output logic                    commit_ready,
  output logic                    trace_valid,
  input  logic                    trace_ready,
  output logic [31:0]             trace_inst,
  output logic [63:0]             trace_dnpc,
  output logic [TRACE_FLAG_W-1:0] trace_flags,
  output logic [SEQ_W-1:0]        trace_seq,
  output logic [63:0]             retired_cnt,
  output logic                    overflow,
  output logic                    timeout
);
  localparam int AW = clog2_safe(DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = clog2_safe(NCH);
  localparam int NW = clog2_safe(NCH + 1);
  localparam int WW = clog2_safe(TIMEOUT + 1);
  trace_entry_t mem [DEPTH];
  trace_entry_t wr_e [NCH];
  trace_entry_t head;
  logic [31:0] inst_a [NCH];
  logic [63:0] dnpc_a [NCH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic [SEQ_W-1:0] seq_ctr;
  logic [WW-1:0] wdog, wdog_nxt;
  logic [NCH-1:0] elig, live;
  logic [NCH*IW-1:0] src;
  logic [NW-1:0] npush, acc_n, nlive;
  logic pop, any_valid, commit_seen, wdog_hit;
  assign elig = DROP_KILLED != 0 ? commit_valid & ~commit_kill : commit_valid;
  assign live = commit_valid & ~commit_kill;
  assign any_valid = |commit_valid;
  assign commit_ready = (CW'(DEPTH) - count) >= CW'(NCH);
  assign acc_n = commit_ready ? npush : '0;
  assign pop = trace_valid && trace_ready;
  assign commit_seen = commit_ready && |live;
  commit_compact #(.NCH(NCH)) u_compact (
    .mask  (elig),
    .src   (src),
    .npush (npush)
  );
  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [IW-1:0] c;
    assign inst_a[k] = commit_inst[32*k +: 32];
    assign dnpc_a[k] = commit_dnpc[64*k +: 64];
    assign c = src[k*IW +: IW];
    assign wr_e[k] = '{
      inst:    inst_a[c],
      dnpc:    dnpc_a[c],
      device:  commit_device[c],
      invalid: commit_invalid[c],
      kill:    commit_kill[c],
      seq:     TRACE_SEQ_W'(seq_ctr + SEQ_W'(k))
    };
  end
  always_comb begin
    nlive = '0;
    for (int i = 0; i < NCH; i++) nlive = nlive + NW'(live[i]);
  end
  assign wdog_nxt = commit_seen ? '0 : (TIMEOUT == 0 || wdog == WW'(TIMEOUT)) ? wdog : wdog + 1'b1;
  assign wdog_hit = TIMEOUT != 0 && wdog_nxt == WW'(TIMEOUT);
  always_ff @(posedge clk) begin
    for (int s = 0; s < NCH; s++)
      if (NW'(s) < acc_n) mem[wptr + AW'(s)] <= wr_e[s];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      seq_ctr     <= '0;
      retired_cnt <= '0;
      overflow    <= 1'b0;
      timeout     <= 1'b0;
      wdog        <= '0;
    end else begin
      wptr        <= wptr + AW'(acc_n);
      rptr        <= rptr + AW'(pop);
      count       <= count + CW'(acc_n) - CW'(pop);
      seq_ctr     <= seq_ctr + SEQ_W'(acc_n);
      retired_cnt <= retired_cnt + (commit_ready ? 64'(nlive) : 64'd0);
      overflow    <= overflow | (any_valid && !commit_ready);
      timeout     <= timeout | wdog_hit;
      wdog        <= wdog_nxt;
    end
  end
  // Storage is not reset, so the head is masked while the FIFO is empty.
  assign head = mem[rptr];
  assign trace_valid = count != '0;
  assign trace_inst  = trace_valid ? head.inst : '0;
  assign trace_dnpc  = trace_valid ? head.dnpc : '0;
  assign trace_flags = trace_valid ? {head.device, head.invalid, head.kill} : '0;
  assign trace_seq   = trace_valid ? head.seq[SEQ_W-1:0] : '0;
endmodule

// File: tb/tb_commit_trace_buffer.sv
// tb_commit_trace_buffer: directed vectors against three configurations sharing one stimulus
module tb_commit_trace_buffer;
  localparam int NCH = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NCH-1:0] valid, kill, inv, dev;
  logic [31:0] inst0, inst1;
  logic [63:0] dnpc0, dnpc1;
  logic tready;
  logic [32*NCH-1:0] cinst;
  logic [64*NCH-1:0] cdnpc;
  logic ready_a, tvalid_a, ovf_a, tmo_a;
  logic ready_b, tvalid_b, ovf_b, tmo_b;
  logic ready_c, tvalid_c, ovf_c, tmo_c;
  logic [31:0] tinst_a, tinst_b, tinst_c, tseq_a, tseq_b, tseq_c;
  logic [63:0] tdnpc_a, tdnpc_b, tdnpc_c, ret_a, ret_b, ret_c;
  logic [2:0] tfl_a, tfl_b, tfl_c;
  int checks = 0;
  int errors = 0;

  assign cinst = {inst1, inst0};
  assign cdnpc = {dnpc1, dnpc0};
  always #5 clk = ~clk;

  commit_trace_buffer #(.NCH(2), .DEPTH(16), .SEQ_W(32), .TIMEOUT(8), .DROP_KILLED(0)) u_a (
    .clk(clk), .rst(rst), .commit_valid(valid), .commit_inst(cinst), .commit_dnpc(cdnpc),
    .commit_kill(kill), .commit_invalid(inv), .commit_device(dev), .commit_ready(ready_a),
    .trace_valid(tvalid_a), .trace_ready(tready), .trace_inst(tinst_a), .trace_dnpc(tdnpc_a),
    .trace_flags(tfl_a), .trace_seq(tseq_a), .retired_cnt(ret_a), .overflow(ovf_a), .timeout(tmo_a));
  commit_trace_buffer #(.NCH(2), .DEPTH(4), .SEQ_W(32), .TIMEOUT(0), .DROP_KILLED(0)) u_b (
    .clk(clk), .rst(rst), .commit_valid(valid), .commit_inst(cinst), .commit_dnpc(cdnpc),
    .commit_kill(kill), .commit_invalid(inv), .commit_device(dev), .commit_ready(ready_b),
    .trace_valid(tvalid_b), .trace_ready(tready), .trace_inst(tinst_b), .trace_dnpc(tdnpc_b),
    .trace_flags(tfl_b), .trace_seq(tseq_b), .retired_cnt(ret_b), .overflow(ovf_b), .timeout(tmo_b));
  commit_trace_buffer #(.NCH(2), .DEPTH(16), .SEQ_W(32), .TIMEOUT(0), .DROP_KILLED(1)) u_c (
    .clk(clk), .rst(rst), .commit_valid(valid), .commit_inst(cinst), .commit_dnpc(cdnpc),
    .commit_kill(kill), .commit_invalid(inv), .commit_device(dev), .commit_ready(ready_c),
    .trace_valid(tvalid_c), .trace_ready(tready), .trace_inst(tinst_c), .trace_dnpc(tdnpc_c),
    .trace_flags(tfl_c), .trace_seq(tseq_c), .retired_cnt(ret_c), .overflow(ovf_c), .timeout(tmo_c));

  typedef struct {
    logic        rst;
    logic [1:0]  valid;
    logic [1:0]  kill;
    logic [1:0]  di;
    logic [31:0] i0;
    logic [31:0] i1;
    logic [63:0] d0;
    logic [63:0] d1;
    logic        tr;
    logic        ev;
    logic [31:0] einst;
    logic [63:0] ednpc;
    logic [2:0]  efl;
    logic [31:0] eseq;
    logic [63:0] eret;
  } vec_t;
  vec_t tbl [11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic r, input logic [1:0] v, input logic [1:0] k,
                       input logic [31:0] a, input logic [31:0] b, input logic t);
    rst = r;
    valid = v;
    kill = k;
    inv = 2'b00;
    dev = 2'b00;
    inst0 = a;
    inst1 = b;
    dnpc0 = 64'(a) + 64'h1000;
    dnpc1 = 64'(b) + 64'h1000;
    tready = t;
  endtask

  initial begin
    tbl[0]  = '{1'b1, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 64'h0, 64'h0, 1'b0,
                1'b0, 32'h0, 64'h0, 3'b000, 32'd0, 64'd0};
    tbl[1]  = '{1'b0, 2'b10, 2'b00, 2'b00, 32'h0, 32'h00100093, 64'h0, 64'h80000004, 1'b0,
                1'b1, 32'h00100093, 64'h80000004, 3'b000, 32'd0, 64'd1};
    tbl[2]  = '{1'b0, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 64'h0, 64'h0, 1'b1,
                1'b0, 32'h0, 64'h0, 3'b000, 32'd0, 64'd1};
    tbl[3]  = '{1'b1, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 64'h0, 64'h0, 1'b0,
                1'b0, 32'h0, 64'h0, 3'b000, 32'd0, 64'd0};
    tbl[4]  = '{1'b0, 2'b11, 2'b00, 2'b00, 32'hA, 32'hB, 64'h100, 64'h104, 1'b1,
                1'b1, 32'hA, 64'h100, 3'b000, 32'd0, 64'd2};
    tbl[5]  = '{1'b0, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 64'h0, 64'h0, 1'b1,
                1'b1, 32'hB, 64'h104, 3'b000, 32'd1, 64'd2};
    tbl[6]  = '{1'b0, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 64'h0, 64'h0, 1'b1,
                1'b0, 32'h0, 64'h0, 3'b000, 32'd0, 64'd2};
    tbl[7]  = '{1'b0, 2'b11, 2'b01, 2'b00, 32'hC, 32'hD, 64'h200, 64'h204, 1'b0,
                1'b1, 32'hC, 64'h200, 3'b001, 32'd2, 64'd3};
    tbl[8]  = '{1'b0, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 64'h0, 64'h0, 1'b1,
                1'b1, 32'hD, 64'h204, 3'b000, 32'd3, 64'd3};
    tbl[9]  = '{1'b0, 2'b01, 2'b00, 2'b01, 32'hE, 32'h0, 64'h300, 64'h0, 1'b1,
                1'b1, 32'hE, 64'h300, 3'b110, 32'd4, 64'd4};
    tbl[10] = '{1'b0, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 64'h0, 64'h0, 1'b1,
                1'b0, 32'h0, 64'h0, 3'b000, 32'd0, 64'd4};

    drive(1'b1, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0);
    tick;
    tick;
    chk("rst.ready", 64'(ready_a), 64'd1);
    chk("rst.valid", 64'(tvalid_a), 64'd0);
    chk("rst.retired", ret_a, 64'd0);
    chk("rst.inst", 64'(tinst_a), 64'd0);
    chk("rst.timeout", 64'(tmo_a), 64'd0);
    rst = 1'b0;
    repeat (7) tick;
    chk("wdog.before", 64'(tmo_a), 64'd0);
    tick;
    chk("wdog.fire", 64'(tmo_a), 64'd1);
    chk("wdog.disabled", 64'(tmo_b), 64'd0);

    for (int i = 0; i < 11; i++) begin
      rst = tbl[i].rst;
      valid = tbl[i].valid;
      kill = tbl[i].kill;
      inv = tbl[i].di;
      dev = tbl[i].di;
      inst0 = tbl[i].i0;
      inst1 = tbl[i].i1;
      dnpc0 = tbl[i].d0;
      dnpc1 = tbl[i].d1;
      tready = tbl[i].tr;
      tick;
      chk($sformatf("v%0d.valid", i), 64'(tvalid_a), 64'(tbl[i].ev));
      chk($sformatf("v%0d.inst", i), 64'(tinst_a), 64'(tbl[i].einst));
      chk($sformatf("v%0d.dnpc", i), tdnpc_a, tbl[i].ednpc);
      chk($sformatf("v%0d.flags", i), 64'(tfl_a), 64'(tbl[i].efl));
      chk($sformatf("v%0d.seq", i), 64'(tseq_a), 64'(tbl[i].eseq));
      chk($sformatf("v%0d.retired", i), ret_a, tbl[i].eret);
      chk($sformatf("v%0d.ready", i), 64'(ready_a), 64'd1);
      if (tbl[i].rst) chk($sformatf("v%0d.timeout", i), 64'(tmo_a), 64'd0);
    end

    drive(1'b1, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0);
    tick;
    drive(1'b0, 2'b11, 2'b01, 32'hC, 32'hD, 1'b0);
    tick;
    chk("drop.valid", 64'(tvalid_c), 64'd1);
    chk("drop.inst", 64'(tinst_c), 64'hD);
    chk("drop.seq", 64'(tseq_c), 64'd0);
    chk("drop.flags", 64'(tfl_c), 64'd0);
    chk("drop.retired", ret_c, 64'd1);
    chk("keep.inst", 64'(tinst_a), 64'hC);
    chk("keep.flags", 64'(tfl_a), 64'd1);
    chk("keep.retired", ret_a, 64'd1);
    drive(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 1'b1);
    tick;
    chk("drop.empty", 64'(tvalid_c), 64'd0);
    chk("keep.inst2", 64'(tinst_a), 64'hD);
    chk("keep.seq2", 64'(tseq_a), 64'd1);

    drive(1'b1, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0);
    tick;
    drive(1'b0, 2'b11, 2'b00, 32'h11, 32'h12, 1'b0);
    tick;
    chk("fill.ready1", 64'(ready_b), 64'd1);
    drive(1'b0, 2'b11, 2'b00, 32'h13, 32'h14, 1'b0);
    tick;
    chk("fill.ready2", 64'(ready_b), 64'd0);
    chk("fill.ovf0", 64'(ovf_b), 64'd0);
    drive(1'b0, 2'b11, 2'b00, 32'h15, 32'h16, 1'b0);
    tick;
    chk("fill.ovf1", 64'(ovf_b), 64'd1);
    chk("fill.ready3", 64'(ready_b), 64'd0);
    chk("fill.retired", ret_b, 64'd4);
    drive(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain%0d.inst", k), 64'(tinst_b), 64'(32'h11 + k));
      chk($sformatf("drain%0d.seq", k), 64'(tseq_b), 64'(k));
      tick;
      if (k == 0) chk("drain.ready_cnt3", 64'(ready_b), 64'd0);
      if (k == 1) chk("drain.ready_cnt2", 64'(ready_b), 64'd1);
    end
    chk("drain.empty", 64'(tvalid_b), 64'd0);
    chk("drain.ovf_sticky", 64'(ovf_b), 64'd1);

    drive(1'b1, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0);
    tick;
    drive(1'b0, 2'b11, 2'b00, 32'h21, 32'h22, 1'b0);
    tick;
    drive(1'b0, 2'b01, 2'b00, 32'h23, 32'h0, 1'b0);
    tick;
    drive(1'b0, 2'b11, 2'b00, 32'h24, 32'h25, 1'b0);
    tick;
    chk("mid.ovf", 64'(ovf_b), 64'd1);
    chk("mid.valid", 64'(tvalid_a), 64'd1);
    drive(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 1'b1);
    tick;
    chk("mid.head", 64'(tinst_a), 64'h22);
    drive(1'b1, 2'b00, 2'b00, 32'h0, 32'h0, 1'b1);
    tick;
    chk("mid.rst_valid_a", 64'(tvalid_a), 64'd0);
    chk("mid.rst_valid_b", 64'(tvalid_b), 64'd0);
    chk("mid.rst_ovf", 64'(ovf_b), 64'd0);
    chk("mid.rst_retired", ret_a, 64'd0);
    chk("mid.rst_ready", 64'(ready_b), 64'd1);
    chk("mid.rst_inst", 64'(tinst_a), 64'd0);
    drive(1'b0, 2'b01, 2'b00, 32'h31, 32'h0, 1'b0);
    tick;
    chk("mid.new_inst", 64'(tinst_a), 64'h31);
    chk("mid.new_seq", 64'(tseq_a), 64'd0);
    chk("mid.new_retired", ret_a, 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
